// File: rtl/i2c_slave_responder_if.sv
// I2C target bus bundle: oversampled SCL/SDA lines plus the register-write side channel.
interface i2c_slave_responder_if;
  logic       scl_i;
  logic       sda_i;
  logic       sda_oe_o;
  logic       wr_valid_o;
  logic [7:0] wr_addr_o;
  logic [7:0] wr_data_o;
  logic       busy_o;
  logic       addr_match_o;

  modport slave (
    input  scl_i, sda_i,
    output sda_oe_o, wr_valid_o, wr_addr_o, wr_data_o, busy_o, addr_match_o
  );

  modport master (
    output scl_i, sda_i,
    input  sda_oe_o, wr_valid_o, wr_addr_o, wr_data_o, busy_o, addr_match_o
  );
endinterface

// File: rtl/i2c_slave_responder.sv
// I2C target serving an auto-incrementing 8-bit register file; samples SCL/SDA with the
// system clock, ACKs its 7-bit address and supports repeated-START random reads.
module i2c_slave_responder #(
  parameter logic [6:0]  SLAVE_ADDR = 7'h50,
  parameter int unsigned REG_DEPTH  = 16
) (
  input logic                  clk,
  input logic                  resetn,
  i2c_slave_responder_if.slave bus
);
  localparam int unsigned PtrW = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1;

  typedef enum logic [3:0] {
    StIdle, StAddr, StAddrAck, StReg, StRegAck, StWrite, StWriteAck, StRead, StReadAck,
    StWaitStop
  } state_e;

  // [0],[1]: synchronizer, [2]: registered copy used for edge decode
  logic [2:0] scl_sync_q, sda_sync_q;
  logic       scl_rise_q, scl_fall_q, start_q, stop_q;
  logic       sda_in;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic [PtrW-1:0]   ptr_q, ptr_d;
  logic              rw_q, rw_d;
  logic              sda_oe_q, sda_oe_d;
  logic              wr_valid_q, wr_valid_d;
  logic [7:0]        wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              busy_q, busy_d;
  logic              match_q, match_d;
  logic              reg_we;
  logic [7:0]        regs_q [REG_DEPTH];
  logic [7:0]        rd_byte;
  logic              byte_done;

  // Reset lines to the idle-high level so release does not fake an edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      scl_sync_q <= 3'b111;
      sda_sync_q <= 3'b111;
      scl_rise_q <= 1'b0;
      scl_fall_q <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
    end else begin
      scl_sync_q <= {scl_sync_q[1:0], bus.scl_i};
      sda_sync_q <= {sda_sync_q[1:0], bus.sda_i};
      scl_rise_q <= scl_sync_q[1] & ~scl_sync_q[2];
      scl_fall_q <= ~scl_sync_q[1] & scl_sync_q[2];
      start_q    <= scl_sync_q[1] & scl_sync_q[2] & ~sda_sync_q[1] & sda_sync_q[2];
      stop_q     <= scl_sync_q[1] & scl_sync_q[2] & sda_sync_q[1] & ~sda_sync_q[2];
    end
  end

  assign sda_in    = sda_sync_q[2];
  assign rd_byte   = regs_q[ptr_q];
  assign byte_done = scl_fall_q && (cnt_q == 4'd8);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    ptr_d      = ptr_q;
    rw_d       = rw_q;
    sda_oe_d   = sda_oe_q;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    busy_d     = busy_q;
    match_d    = match_q;
    reg_we     = 1'b0;

    if (start_q) begin
      state_d  = StAddr;
      cnt_d    = '0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b1;
      match_d  = 1'b0;
    end else if (stop_q) begin
      state_d  = StIdle;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
      match_d  = 1'b0;
    end else begin
      unique case (state_q)
        StAddr, StReg, StWrite: begin
          if (scl_rise_q && (cnt_q < 4'd8)) begin
            shift_d = {shift_q[6:0], sda_in};
            cnt_d   = cnt_q + 4'd1;
          end else if (byte_done) begin
            cnt_d = '0;
            if (state_q == StAddr) begin
              // Address 0 (general call) is never claimed.
              if ((shift_q[7:1] == SLAVE_ADDR) && (shift_q[7:1] != 7'd0)) begin
                state_d  = StAddrAck;
                sda_oe_d = 1'b1;
                match_d  = 1'b1;
                rw_d     = shift_q[0];
              end else begin
                state_d = StIdle;
              end
            end else if (state_q == StReg) begin
              state_d  = StRegAck;
              sda_oe_d = 1'b1;
              ptr_d    = shift_q[PtrW-1:0];
            end else begin
              state_d    = StWriteAck;
              sda_oe_d   = 1'b1;
              reg_we     = 1'b1;
              wr_valid_d = 1'b1;
              wr_addr_d  = 8'(ptr_q);
              wr_data_d  = shift_q;
              ptr_d      = ptr_q + PtrW'(1);
            end
          end
        end
        StAddrAck: begin
          // Reads preload on the ACK rise; the following fall swaps ACK for bit 7.
          if (rw_q && scl_rise_q) begin
            shift_d = rd_byte;
            cnt_d   = '0;
            state_d = StRead;
          end else if (!rw_q && scl_fall_q) begin
            sda_oe_d = 1'b0;
            state_d  = StReg;
          end
        end
        StRegAck, StWriteAck: begin
          if (scl_fall_q) begin
            sda_oe_d = 1'b0;
            state_d  = StWrite;
          end
        end
        StRead: begin
          if (scl_fall_q) begin
            if (cnt_q < 4'd8) begin
              sda_oe_d = ~shift_q[7];
              shift_d  = {shift_q[6:0], 1'b0};
              cnt_d    = cnt_q + 4'd1;
            end else begin
              sda_oe_d = 1'b0;
              ptr_d    = ptr_q + PtrW'(1);
              state_d  = StReadAck;
            end
          end
        end
        StReadAck: begin
          if (scl_rise_q) begin
            if (!sda_in) begin
              shift_d = rd_byte;
              cnt_d   = '0;
              state_d = StRead;
            end else begin
              state_d = StWaitStop;
            end
          end
        end
        StIdle, StWaitStop: ;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      shift_q    <= '0;
      ptr_q      <= '0;
      rw_q       <= 1'b0;
      sda_oe_q   <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
      match_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      ptr_q      <= ptr_d;
      rw_q       <= rw_d;
      sda_oe_q   <= sda_oe_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
      match_q    <= match_d;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < REG_DEPTH; i++) regs_q[i] <= '0;
    end else if (reg_we) begin
      regs_q[ptr_q] <= shift_q;
    end
  end

  assign bus.sda_oe_o     = sda_oe_q;
  assign bus.wr_valid_o   = wr_valid_q;
  assign bus.wr_addr_o    = wr_addr_q;
  assign bus.wr_data_o    = wr_data_q;
  assign bus.busy_o       = busy_q;
  assign bus.addr_match_o = match_q;
endmodule

// File: tb/tb_i2c_slave_responder.sv
// Bench for i2c_slave_responder: bit-banged I2C master, byte-level register-file model,
// directed scenarios followed by randomized write / random-read / current-address-read traffic.
module tb_i2c_slave_responder;
  localparam int Half = 10;  // clk cycles per SCL phase

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic scl_m = 1'b1;
  logic sda_m = 1'b1;

  i2c_slave_responder_if bus();
  assign bus.scl_i = scl_m;
  assign bus.sda_i = sda_m & ~bus.sda_oe_o;  // open-drain wired-AND

  i2c_slave_responder #(.SLAVE_ADDR(7'h50), .REG_DEPTH(16)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Byte-level model: phase 0 none, 1 address, 2 register index, 3 write data, 4 read data.
  logic [7:0]  m_regs [16];
  int          m_ptr = 0;
  int          m_phase = 0;
  logic        m_match = 1'b0;
  logic [15:0] exp_wr_q [$];
  logic [7:0]  got;
  logic        prev_wv = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic model_write_byte(input logic [7:0] b);
    logic ack;
    ack = 1'b0;
    case (m_phase)
      1: begin
        m_match = (b[7:1] == 7'h50);
        ack     = m_match;
        m_phase = !m_match ? 0 : (b[0] ? 4 : 2);
      end
      2: begin
        m_ptr   = int'(b) % 16;
        ack     = 1'b1;
        m_phase = 3;
      end
      3: begin
        m_regs[m_ptr] = b;
        exp_wr_q.push_back({8'(m_ptr), b});
        m_ptr = (m_ptr + 1) % 16;
        ack   = 1'b1;
      end
      default: ack = 1'b0;
    endcase
    return ack;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One SCL period starting just after a fall; reports line and slave drive mid-high.
  task automatic bit_cycle(input logic mbit, output logic line, output logic oe);
    tick(Half / 2);
    sda_m = mbit;
    tick(Half / 2);
    scl_m = 1'b1;
    tick(Half / 2);
    line = bus.sda_i;
    oe   = bus.sda_oe_o;
    tick(Half / 2);
    scl_m = 1'b0;
  endtask

  task automatic i2c_start();
    if (!scl_m) begin
      tick(Half / 2);
      sda_m = 1'b1;
      tick(Half / 2);
      scl_m = 1'b1;
    end
    tick(Half / 2);
    sda_m = 1'b0;
    tick(Half / 2);
    check("busy after START", bus.busy_o, 1'b1);
    check("addr_match cleared by START", bus.addr_match_o, 1'b0);
    scl_m   = 1'b0;
    m_phase = 1;
    m_match = 1'b0;
  endtask

  task automatic i2c_stop();
    tick(Half / 2);
    sda_m = 1'b0;
    tick(Half / 2);
    scl_m = 1'b1;
    tick(Half / 2);
    sda_m = 1'b1;
    tick(Half);
    m_phase = 0;
    m_match = 1'b0;
    check("busy after STOP", bus.busy_o, 1'b0);
    check("addr_match after STOP", bus.addr_match_o, 1'b0);
    check("sda_oe after STOP", bus.sda_oe_o, 1'b0);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    logic line, oe;
    for (int i = 7; i > 7 - n; i--) begin
      bit_cycle(b[i], line, oe);
      check("slave quiet during master bit", oe, 1'b0);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic exp_ack, line, oe;
    exp_ack = model_write_byte(b);
    send_bits(b, 8);
    bit_cycle(1'b1, line, oe);
    check("ack drive", oe, exp_ack);
    check("addr_match", bus.addr_match_o, m_match);
    check("busy mid-transfer", bus.busy_o, 1'b1);
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] data);
    logic [7:0] exp;
    logic line, oe;
    exp     = m_regs[m_ptr];
    m_ptr   = (m_ptr + 1) % 16;
    for (int i = 7; i >= 0; i--) begin
      bit_cycle(1'b1, line, oe);
      data[i] = line;
    end
    check("read data", data, exp);
    bit_cycle(!mack, line, oe);
    check("slave releases in master ACK slot", oe, 1'b0);
    if (!mack) m_phase = 0;
  endtask

  always @(negedge clk) begin
    if (resetn && bus.wr_valid_o) begin
      check("wr_valid single cycle", prev_wv, 1'b0);
      check("wr_valid expected", exp_wr_q.size() > 0, 1'b1);
      if (exp_wr_q.size() > 0) check("wr addr/data", {bus.wr_addr_o, bus.wr_data_o},
                                      exp_wr_q.pop_front());
    end
    prev_wv <= bus.wr_valid_o;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1);
  end

  initial begin
    int kind, n, reg_idx;
    logic [6:0] a;
    for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;

    tick(3);
    check("reset sda_oe", bus.sda_oe_o, 1'b0);
    check("reset wr_valid", bus.wr_valid_o, 1'b0);
    check("reset wr_addr", bus.wr_addr_o, 8'h00);
    check("reset wr_data", bus.wr_data_o, 8'h00);
    check("reset busy", bus.busy_o, 1'b0);
    check("reset addr_match", bus.addr_match_o, 1'b0);
    resetn = 1'b1;
    tick(4);

    // Write 0x5A, 0xC3 starting at register 3.
    i2c_start();
    send_byte(8'hA0); send_byte(8'h03); send_byte(8'h5A); send_byte(8'hC3);
    i2c_stop();
    check("last wr_addr", bus.wr_addr_o, 8'd4);
    check("last wr_data", bus.wr_data_o, 8'hC3);
    check("model regs[3]", m_regs[3], 8'h5A);
    check("model regs[4]", m_regs[4], 8'hC3);

    // Random read through a repeated START.
    i2c_start();
    send_byte(8'hA0); send_byte(8'h03);
    i2c_start();
    send_byte(8'hA1);
    read_byte(1'b1, got); check("random read byte 0", got, 8'h5A);
    read_byte(1'b0, got); check("random read byte 1", got, 8'hC3);
    i2c_stop();
    check("model ptr after read", m_ptr, 5);
    i2c_start(); send_byte(8'hA1); read_byte(1'b0, got); i2c_stop();  // reads regs[5]

    // Foreign address: must stay silent.
    i2c_start();
    send_byte(8'hA2); send_byte(8'h00); send_byte(8'hFF);
    i2c_stop();
    check("wr_addr held", bus.wr_addr_o, 8'd4);

    // Pointer wrap from register 15.
    i2c_start();
    send_byte(8'hA0); send_byte(8'h0F); send_byte(8'h11); send_byte(8'h22);
    i2c_stop();
    check("wrap wr_addr", bus.wr_addr_o, 8'd0);
    check("wrap wr_data", bus.wr_data_o, 8'h22);
    i2c_start(); send_byte(8'hA0); send_byte(8'h0F); i2c_start(); send_byte(8'hA1);
    read_byte(1'b1, got); check("wrap read regs[15]", got, 8'h11);
    read_byte(1'b0, got); check("wrap read regs[0]", got, 8'h22);
    i2c_stop();

    // STOP after half a data byte: partial byte discarded.
    i2c_start();
    send_byte(8'hA0); send_byte(8'h07); send_bits(8'hA5, 4);
    i2c_stop();
    i2c_start(); send_byte(8'hA1); read_byte(1'b0, got); i2c_stop();  // regs[7] untouched

    // Randomized traffic.
    for (int t = 0; t < 16; t++) begin
      kind    = $urandom_range(0, 2);
      n       = $urandom_range(1, 3);
      reg_idx = $urandom_range(0, 255);
      a       = ($urandom_range(0, 5) == 0) ? 7'($urandom) : 7'h50;
      i2c_start();
      if (kind == 0) begin
        send_byte({a, 1'b0});
        send_byte(8'(reg_idx));
        for (int k = 0; k < n; k++) send_byte(8'($urandom));
      end else begin
        if (kind == 1) begin
          send_byte({7'h50, 1'b0});
          send_byte(8'(reg_idx));
          i2c_start();
        end
        send_byte({7'h50, 1'b1});
        for (int k = 0; k < n; k++) read_byte(k < n - 1, got);
      end
      i2c_stop();
    end
    check("no outstanding writes", exp_wr_q.size(), 0);

    // Reset while the address ACK is being driven.
    i2c_start();
    send_bits(8'hA0, 8);
    tick(Half / 2);
    sda_m = 1'b1;
    tick(Half / 2);
    scl_m = 1'b1;
    tick(Half / 2);
    check("ACK driven before reset", bus.sda_oe_o, 1'b1);
    resetn = 1'b0;
    #1;
    check("sda_oe cleared by reset", bus.sda_oe_o, 1'b0);
    check("busy cleared by reset", bus.busy_o, 1'b0);
    check("wr_addr cleared by reset", bus.wr_addr_o, 8'h00);
    check("wr_data cleared by reset", bus.wr_data_o, 8'h00);
    scl_m = 1'b1;
    sda_m = 1'b1;
    tick(4);
    resetn = 1'b1;
    for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
    m_ptr   = 0;
    m_phase = 0;
    m_match = 1'b0;
    tick(4);
    i2c_start();
    send_byte(8'hA1);
    for (int k = 0; k < 16; k++) begin
      read_byte(k < 15, got);
      check("reg cleared by reset", got, 8'h00);
    end
    i2c_stop();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
